pipelined_frame_accumulator: RTL
================================

Name: pipelined_frame_accumulator

Overview:
- Streaming successor to the combinational term summer.
- Each accepted beat carries NUM_ELEMENTS words. They are summed through a registered adder tree with one register per tree level.
- In FRAME_MODE the per-beat sums are accumulated across a frame delimited by in_last. Otherwise every beat's sum is emitted.
- Sits between operand producers (multiplier arrays, MAC lanes) and the result writeback stage. Uses valid/ready handshakes on both sides.

Parameters:
- NUM_ELEMENTS, 9, words per input beat (>=1).
- WORD_LEN, 8, width of each input word.
- SIGNED, 0, 1 = words and sums are two's-complement (sign-extend), 0 = unsigned (zero-extend).
- FRAME_MODE, 1, 1 = accumulate beats until in_last, 0 = output every beat.
- SUM_LEN, WORD_LEN+$clog2(NUM_ELEMENTS), width of the tree result (derived, not overridden).
- ACC_LEN, SUM_LEN+8, accumulator and output width; must be >= SUM_LEN.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  beat present.
- in_ready  output  1  beat accepted when in_valid & in_ready.
- in_terms  input  [WORD_LEN-1:0] x NUM_ELEMENTS (unpacked array)  operand words.
- in_last  input  1  final beat of frame (ignored when FRAME_MODE=0).
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- out_sum  output  ACC_LEN  result.

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - All pipeline valid bits, data registers, out_valid and out_sum clear to 0.
  - Internal first_flag sets to 1.
  - Reset mid-frame discards all partial accumulation. The next accepted beat starts a new frame.
- Tree structure:
  - LEVELS = max(1, $clog2(NUM_ELEMENTS)).
  - Level k adds adjacent pairs from level k-1. An odd leftover passes through registered.
  - Words extend to SUM_LEN before the first add (sign- or zero-extend per SIGNED). No truncation inside the tree.
- Accumulator stage: one register after the tree. Tree sum extends to ACC_LEN.
  - FRAME_MODE=1, first_flag=1: acc = sum.
  - FRAME_MODE=1, otherwise: acc = acc + sum, modulo 2^ACC_LEN.
  - The beat tagged last sets out_valid and sets first_flag. Other beats clear first_flag and leave out_valid low.
  - FRAME_MODE=0: acc = sum and out_valid=1 for every beat.
- Latency: LEVELS+1 cycles from accepted beat to out_valid (last beat, FRAME_MODE=1). For NUM_ELEMENTS=9: 5 cycles.
- Throughput: one beat per cycle when out_ready=1.
- Backpressure:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - Every pipeline register, including the valid/last tag bits, holds while stall=1.
  - out_sum and out_valid remain stable while stalled.
  - Bubbles are not collapsed.
- Output handshake:
  - out_valid drops the cycle after out_valid & out_ready, unless a new result lands the same cycle.
  - A new result may land the same cycle the old one is taken.
- in_valid=0 inserts a bubble. Bubbles never modify acc or first_flag.
- in_last with in_valid=0 has no effect.

Optional Feature:
- Macro: PIPELINED_FRAME_ACCUMULATOR_OVF_EN.
- Defined:
  - Adds output port out_ovf (1 bit), reset 0, valid with out_valid.
  - Sticky per frame. It is set by any accumulator add that overflows ACC_LEN: unsigned carry-out, or signed overflow (operands same sign, result sign differs).
  - Cleared when the first beat of the next frame is accumulated.
  - FRAME_MODE=0: always 0.
  - Result still wraps.
- Undefined: port absent, wrap is silent, no extra logic.

Test Plan:
- NUM_ELEMENTS=9, WORD_LEN=8, FRAME_MODE=0; one beat with all terms 255, out_ready=1 -> out_valid exactly 5 cycles later, out_sum=2295, held one cycle.
- FRAME_MODE=1; 3 back-to-back beats with terms 1..9, in_last on beat 3 -> single out_valid pulse, out_sum=135, no output on beats 1-2.
- out_ready=0 while result pending, 4 more beats offered -> in_ready=0, out_sum stable at 135, no beat lost; release out_ready -> next frames complete with correct sums.
- SIGNED=1, FRAME_MODE=0, all terms 8'hFF -> out_sum = -9 sign-extended (all ones except ...F7).
- Reset asserted after 2 beats of a frame, then 1 beat of terms 1..9 with in_last -> out_sum=45 (no carry-over), outputs 0 during reset.
- With OVF_EN macro, ACC_LEN=12, frame of 2 beats each all-255 -> out_sum=494, out_ovf=1; next single-beat frame with terms 1..9 -> out_sum=45, out_ovf=0.

Source files
------------

// File: rtl/pipelined_frame_accumulator_if.sv
// Handshake bundle for pipelined_frame_accumulator.
// The beat side (in_*) and the result side (out_*) share one interface.
// The slave modport belongs to the accumulator.
// The master modport belongs to whatever produces beats and consumes results.
// With PIPELINED_FRAME_ACCUMULATOR_OVF_EN defined, an out_ovf flag travels with out_sum.
interface pipelined_frame_accumulator_if #(
    parameter int NUM_ELEMENTS = 9,
    parameter int WORD_LEN     = 8,
    parameter int ACC_LEN      = 20
);
    logic                in_valid;
    logic                in_ready;
    logic [WORD_LEN-1:0] in_terms [NUM_ELEMENTS];
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [ACC_LEN-1:0]  out_sum;
`ifdef PIPELINED_FRAME_ACCUMULATOR_OVF_EN
    logic                out_ovf;
`endif

    modport master (
        output in_valid, in_terms, in_last, out_ready,
`ifdef PIPELINED_FRAME_ACCUMULATOR_OVF_EN
        input  out_ovf,
`endif
        input  in_ready, out_valid, out_sum
    );

    modport slave (
        input  in_valid, in_terms, in_last, out_ready,
`ifdef PIPELINED_FRAME_ACCUMULATOR_OVF_EN
        output out_ovf,
`endif
        output in_ready, out_valid, out_sum
    );
endinterface

// File: rtl/pipelined_frame_accumulator.sv
// pipelined_frame_accumulator: registered adder tree followed by a frame accumulator.
// Each beat of NUM_ELEMENTS words is reduced pairwise, with one register per tree level.
// The beat sum is then either emitted directly (FRAME_MODE=0) or accumulated until in_last.
// A single stall signal freezes every stage while a result waits for out_ready.
// Optional macro PIPELINED_FRAME_ACCUMULATOR_OVF_EN adds a sticky per-frame overflow flag.
module pipelined_frame_accumulator #(
    parameter int NUM_ELEMENTS = 9,
    parameter int WORD_LEN     = 8,
    parameter int SIGNED       = 0,
    parameter int FRAME_MODE   = 1,
    parameter int ACC_LEN      = WORD_LEN + $clog2(NUM_ELEMENTS) + 8
) (
    input logic clk,
    input logic rst_n,
    pipelined_frame_accumulator_if.slave bus
);
    localparam int SUM_LEN = WORD_LEN + $clog2(NUM_ELEMENTS);
    localparam int LEVELS  = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;

    // Number of live nodes at a given tree level (level 0 = the input words).
    function automatic int level_count(input int k);
        int c;
        c = NUM_ELEMENTS;
        for (int i = 0; i < k; i++) c = (c + 1) / 2;
        return c;
    endfunction

    logic [SUM_LEN-1:0] leaf   [NUM_ELEMENTS];
    logic [SUM_LEN-1:0] tree_d [1:LEVELS][NUM_ELEMENTS];
    logic [SUM_LEN-1:0] tree_q [1:LEVELS][NUM_ELEMENTS];
    logic [LEVELS:1]    valid_q;
    logic [LEVELS:1]    last_q;
    logic [ACC_LEN-1:0] acc_q;
    logic [ACC_LEN-1:0] acc_next;
    logic [ACC_LEN-1:0] sum_ext;
    logic               out_valid_q;
    logic               first_q;
    logic               stall;

    assign stall         = out_valid_q & ~bus.out_ready;
    assign bus.in_ready  = ~stall;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = acc_q;

    // Widen every input word to the tree width, sign- or zero-filling the top bits.
    always_comb begin
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            leaf[i] = {SUM_LEN{(SIGNED != 0) && bus.in_terms[i][WORD_LEN-1]}};
            leaf[i][WORD_LEN-1:0] = bus.in_terms[i];
        end
    end

    // Each level adds neighbour pairs of the level below; an odd leftover passes through.
    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        localparam int PREV = level_count(k - 1);
        localparam int CUR  = level_count(k);
        for (genvar i = 0; i < NUM_ELEMENTS; i++) begin : g_node
            if (i >= CUR) begin : g_dead
                assign tree_d[k][i] = '0;
            end else if (k == 1) begin : g_first
                if (2 * i + 1 < PREV) begin : g_pair
                    assign tree_d[k][i] = leaf[2*i] + leaf[2*i+1];
                end else begin : g_pass
                    assign tree_d[k][i] = leaf[2*i];
                end
            end else begin : g_inner
                if (2 * i + 1 < PREV) begin : g_pair
                    assign tree_d[k][i] = tree_q[k-1][2*i] + tree_q[k-1][2*i+1];
                end else begin : g_pass
                    assign tree_d[k][i] = tree_q[k-1][2*i];
                end
            end
        end
    end

    // Tree registers and their valid/last tags advance together and freeze on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= LEVELS; k++)
                for (int i = 0; i < NUM_ELEMENTS; i++)
                    tree_q[k][i] <= '0;
            valid_q <= '0;
            last_q  <= '0;
        end else if (!stall) begin
            for (int k = 1; k <= LEVELS; k++)
                for (int i = 0; i < NUM_ELEMENTS; i++)
                    tree_q[k][i] <= tree_d[k][i];
            valid_q[1] <= bus.in_valid;
            last_q[1]  <= bus.in_valid & bus.in_last;
            for (int k = 2; k <= LEVELS; k++) begin
                valid_q[k] <= valid_q[k-1];
                last_q[k]  <= last_q[k-1];
            end
        end
    end

    // Widen the finished tree sum to the accumulator width.
    always_comb begin
        sum_ext = {ACC_LEN{(SIGNED != 0) && tree_q[LEVELS][0][SUM_LEN-1]}};
        sum_ext[SUM_LEN-1:0] = tree_q[LEVELS][0];
    end

`ifdef PIPELINED_FRAME_ACCUMULATOR_OVF_EN
    logic [ACC_LEN:0] add_full;
    logic             add_ovf;
    logic             ovf_q;

    assign add_full    = {1'b0, acc_q} + {1'b0, sum_ext};
    assign acc_next    = add_full[ACC_LEN-1:0];
    assign add_ovf     = (SIGNED != 0)
                       ? ((acc_q[ACC_LEN-1] == sum_ext[ACC_LEN-1]) &&
                          (add_full[ACC_LEN-1] != acc_q[ACC_LEN-1]))
                       : add_full[ACC_LEN];
    assign bus.out_ovf = ovf_q;

    // Sticky overflow for the frame in progress; a frame's first beat starts it clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (!stall && valid_q[LEVELS]) begin
            if (FRAME_MODE == 0 || first_q) ovf_q <= 1'b0;
            else                            ovf_q <= ovf_q | add_ovf;
        end
    end
`else
    assign acc_next = acc_q + sum_ext;
`endif

    // Accumulator stage: starts or extends a frame, and raises out_valid on the frame's last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            first_q     <= 1'b1;
        end else if (!stall) begin
            if (valid_q[LEVELS]) begin
                if (FRAME_MODE != 0) begin
                    acc_q       <= first_q ? sum_ext : acc_next;
                    out_valid_q <= last_q[LEVELS];
                    first_q     <= last_q[LEVELS];
                end else begin
                    acc_q       <= sum_ext;
                    out_valid_q <= 1'b1;
                end
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule
